// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Instruction-type encodings, FSM states and the bundled stage-control vector.
package hazard_pkg;

    localparam logic [3:0] ITYPE_LOAD      = 4'd2;
    localparam logic [3:0] ITYPE_STORE     = 4'd3;
    localparam logic [3:0] ITYPE_PIXEL_MIN = 4'd10;

    typedef enum logic [1:0] {RUN, LU_STALL, FLUSH, MEM_WAIT} hz_state_t;

    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic ifid_flush;
        logic idex_en;
        logic idex_bubble;
        logic exmem_en;
        logic memwb_en;
    } hz_ctrl_t;

    // Field order: pc, ifid, ifid_flush, idex, idex_bubble, exmem, memwb
    localparam hz_ctrl_t CTRL_RUN    = hz_ctrl_t'(7'b1101011);
    localparam hz_ctrl_t CTRL_BRANCH = hz_ctrl_t'(7'b1111111);
    localparam hz_ctrl_t CTRL_FLUSH  = hz_ctrl_t'(7'b1111011);
    localparam hz_ctrl_t CTRL_LU     = hz_ctrl_t'(7'b0001111);
    localparam hz_ctrl_t CTRL_FREEZE = hz_ctrl_t'(7'b0000000);
    localparam hz_ctrl_t CTRL_RESET  = hz_ctrl_t'(7'b0010100);

    function automatic logic is_memop(input logic [3:0] itype);
        return (itype == ITYPE_LOAD) || (itype == ITYPE_STORE) || (itype >= ITYPE_PIXEL_MIN);
    endfunction

endpackage

// File: rtl/hazard_unit_timer.sv
// Memory-wait cycle counter: start loads 1, inc counts up, clear returns to 0.
// tc_o flags that the count has reached MEM_TIMEOUT.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start_i,
    input  logic inc_i,
    input  logic clr_i,
    output logic tc_o
);

    localparam int TW = $clog2(MEM_TIMEOUT + 1);

    logic [TW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)        cnt_d = '0;
        else if (start_i) cnt_d = TW'(1);
        else if (inc_i)   cnt_d = cnt_q + TW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign tc_o = (cnt_q == TW'(MEM_TIMEOUT));

endmodule

// File: rtl/hazard_unit.sv
// Pipeline stall/flush controller: load-use bubbles, taken-branch flushes and
// whole-pipe freezes while data memory is busy, plus a stall-cycle counter.
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int BRANCH_PENALTY = 2,
    parameter int MEM_TIMEOUT    = 64,
    parameter int CNT_W          = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       ifid_rs,
    input  logic [4:0]       ifid_rt,
    input  logic             ifid_rs_valid,
    input  logic             ifid_rt_valid,
    input  logic [3:0]       idex_instr_type,
    input  logic [4:0]       idex_wba,
    input  logic [3:0]       exmem_instr_type,
    input  logic             branch_taken,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_bubble,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int PW = (BRANCH_PENALTY > 1) ? $clog2(BRANCH_PENALTY) : 1;
    localparam logic [PW-1:0] PEN_RELOAD = PW'(BRANCH_PENALTY - 1);

    hz_state_t        state_q, state_d, ret_q, ret_d, base;
    logic [PW-1:0]    cnt_q, cnt_d;
    logic             to_q, to_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic             mem_stall, load_use, wait_en, tc;
    logic             tmr_start, tmr_inc, tmr_clr;
    hz_ctrl_t         ctrl, ctrl_o;

    assign mem_stall = is_memop(exmem_instr_type) & ~mem_ready;
    assign load_use  = (idex_instr_type == ITYPE_LOAD) && (idex_wba != 5'd0) &&
                       ((ifid_rs_valid && (ifid_rs == idex_wba)) ||
                        (ifid_rt_valid && (ifid_rt == idex_wba)));

    mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (tmr_start),
        .inc_i   (tmr_inc),
        .clr_i   (tmr_clr),
        .tc_o    (tc)
    );

    // A release cycle out of MEM_WAIT is evaluated as the state it returns to,
    // with the memory-wait term suppressed since the access just completed.
    always_comb begin
        ctrl      = CTRL_RUN;
        state_d   = state_q;
        ret_d     = ret_q;
        cnt_d     = cnt_q;
        to_d      = to_q;
        tmr_start = 1'b0;
        tmr_inc   = 1'b0;
        tmr_clr   = 1'b0;
        base      = state_q;
        wait_en   = 1'b1;

        if (state_q == MEM_WAIT) begin
            wait_en = 1'b0;
            if (mem_ready) begin
                base    = ret_q;
                tmr_clr = 1'b1;
            end else if (tc) begin
                base    = RUN;
                to_d    = 1'b1;
                tmr_clr = 1'b1;
            end else begin
                ctrl            = CTRL_FREEZE;
                ctrl.ifid_flush = (ret_q == FLUSH);
                tmr_inc         = 1'b1;
            end
        end

        if (base != MEM_WAIT) begin
            if (wait_en && mem_stall) begin
                ctrl            = CTRL_FREEZE;
                ctrl.ifid_flush = (base == FLUSH);
                state_d         = MEM_WAIT;
                ret_d           = (base == FLUSH) ? FLUSH : RUN;
                tmr_start       = 1'b1;
            end else if (base == LU_STALL) begin
                state_d = RUN;
            end else if (branch_taken) begin
                ctrl    = CTRL_BRANCH;
                cnt_d   = PEN_RELOAD;
                state_d = (BRANCH_PENALTY > 1) ? FLUSH : RUN;
            end else if (base == FLUSH) begin
                ctrl    = CTRL_FLUSH;
                cnt_d   = cnt_q - PW'(1);
                state_d = (cnt_q == PW'(1)) ? RUN : FLUSH;
            end else if (load_use) begin
                ctrl    = CTRL_LU;
                state_d = LU_STALL;
            end else begin
                state_d = RUN;
            end
        end
    end

    assign ctrl_o = rst_n ? ctrl : CTRL_RESET;

    always_comb begin
        stall_d = stall_q;
        if (!ctrl_o.pc_en && (stall_q != {CNT_W{1'b1}}))
            stall_d = stall_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            ret_q   <= RUN;
            cnt_q   <= '0;
            to_q    <= 1'b0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            cnt_q   <= cnt_d;
            to_q    <= to_d;
            stall_q <= stall_d;
        end
    end

    assign pc_en        = ctrl_o.pc_en;
    assign ifid_en      = ctrl_o.ifid_en;
    assign ifid_flush   = ctrl_o.ifid_flush;
    assign idex_en      = ctrl_o.idex_en;
    assign idex_bubble  = ctrl_o.idex_bubble;
    assign exmem_en     = ctrl_o.exmem_en;
    assign memwb_en     = ctrl_o.memwb_en;
    assign mem_timeout  = to_q;
    assign stall_cycles = stall_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Randomized and directed bench for hazard_unit against a behavioural model of
// pending flushes, load-use shadows and memory-wait lengths.
module tb_hazard_unit;

    localparam int BP = 2;
    localparam int TO = 64;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic [4:0]  ifid_rs, ifid_rt, idex_wba;
    logic        ifid_rs_valid, ifid_rt_valid, branch_taken, mem_ready;
    logic [3:0]  idex_instr_type, exmem_instr_type;
    logic        pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en, memwb_en, mem_timeout;
    logic [31:0] stall_cycles;
    logic        s_pc_en, s_ifid_en, s_ifid_flush, s_idex_en, s_idex_bubble, s_exmem_en, s_memwb_en, s_mem_timeout;
    logic [3:0]  s_stall_cycles;

    always #5 clk = ~clk;

    hazard_unit #(.BRANCH_PENALTY(BP), .MEM_TIMEOUT(TO), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
        .ifid_rs_valid(ifid_rs_valid), .ifid_rt_valid(ifid_rt_valid),
        .idex_instr_type(idex_instr_type), .idex_wba(idex_wba),
        .exmem_instr_type(exmem_instr_type), .branch_taken(branch_taken), .mem_ready(mem_ready),
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_en(idex_en),
        .idex_bubble(idex_bubble), .exmem_en(exmem_en), .memwb_en(memwb_en),
        .mem_timeout(mem_timeout), .stall_cycles(stall_cycles));

    // Narrow-counter copy on the same inputs, to exercise counter saturation.
    hazard_unit #(.BRANCH_PENALTY(BP), .MEM_TIMEOUT(TO), .CNT_W(4)) dut_s (
        .clk(clk), .rst_n(rst_n), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
        .ifid_rs_valid(ifid_rs_valid), .ifid_rt_valid(ifid_rt_valid),
        .idex_instr_type(idex_instr_type), .idex_wba(idex_wba),
        .exmem_instr_type(exmem_instr_type), .branch_taken(branch_taken), .mem_ready(mem_ready),
        .pc_en(s_pc_en), .ifid_en(s_ifid_en), .ifid_flush(s_ifid_flush), .idex_en(s_idex_en),
        .idex_bubble(s_idex_bubble), .exmem_en(s_exmem_en), .memwb_en(s_memwb_en),
        .mem_timeout(s_mem_timeout), .stall_cycles(s_stall_cycles));

    int n_chk = 0, n_fail = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    int     flush_left, wait_cycles;
    bit     lu_shadow, waiting, to_flag;
    longint stalls;

    task automatic model_reset();
        flush_left = 0; wait_cycles = 0; lu_shadow = 0; waiting = 0; to_flag = 0; stalls = 0;
    endtask

    function automatic logic [6:0] ctrl_vec();
        return {pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en, memwb_en};
    endfunction

    task automatic step_check();
        logic [6:0] exp;
        bit memop, lu, released;
        @(negedge clk);
        check("stall_cycles", stall_cycles, stalls);
        check("stall_sat", s_stall_cycles, (stalls > 15) ? 15 : stalls);
        check("mem_timeout", mem_timeout, to_flag);
        memop = (exmem_instr_type == 2) || (exmem_instr_type == 3) || (exmem_instr_type >= 10);
        lu = (idex_instr_type == 2) && (idex_wba != 0) &&
             ((ifid_rs_valid && ifid_rs == idex_wba) || (ifid_rt_valid && ifid_rt == idex_wba));
        released = 0;
        exp = 7'b1101011;
        if (waiting) begin
            if (mem_ready || wait_cycles == TO) begin
                released = 1; waiting = 0;
                if (!mem_ready) begin to_flag = 1; flush_left = 0; end
            end else begin
                exp = (flush_left > 0) ? 7'b0010000 : 7'b0000000;
                wait_cycles++;
            end
        end
        if (!waiting) begin
            if (!released && memop && !mem_ready) begin
                exp = (flush_left > 0) ? 7'b0010000 : 7'b0000000;
                waiting = 1; wait_cycles = 1; lu_shadow = 0;
            end else if (lu_shadow) begin
                exp = 7'b1101011; lu_shadow = 0;
            end else if (branch_taken) begin
                exp = 7'b1111111; flush_left = BP - 1;
            end else if (flush_left > 0) begin
                exp = 7'b1111011; flush_left--;
            end else if (lu) begin
                exp = 7'b0001111; lu_shadow = 1;
            end else begin
                exp = 7'b1101011;
            end
        end
        check("ctrl", ctrl_vec(), exp);
        check("ctrl_narrow", {s_pc_en, s_ifid_en, s_ifid_flush, s_idex_en, s_idex_bubble, s_exmem_en, s_memwb_en}, exp);
        if (!exp[6]) stalls++;
    endtask

    task automatic cyc();
        step_check();
        @(posedge clk);
        #1;
    endtask

    task automatic setin(input logic [3:0] it, input logic [4:0] wba, input logic [4:0] rs,
                         input logic rsv, input logic [4:0] rt, input logic rtv,
                         input logic [3:0] et, input logic br, input logic rdy);
        idex_instr_type = it; idex_wba = wba; ifid_rs = rs; ifid_rs_valid = rsv;
        ifid_rt = rt; ifid_rt_valid = rtv; exmem_instr_type = et; branch_taken = br; mem_ready = rdy;
    endtask

    task automatic rand_in();
        logic [3:0] it, et;
        it = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'd2;
        et = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
        setin(it, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom),
              5'($urandom_range(0, 3)), 1'($urandom), et,
              ($urandom_range(0, 5) == 0), ($urandom_range(0, 9) < 7));
    endtask

    initial begin
        model_reset();
        setin(0, 0, 0, 0, 0, 0, 0, 0, 1);
        #2;
        check("reset_ctrl", ctrl_vec(), 7'b0010100);
        check("reset_stall", stall_cycles, 0);
        check("reset_timeout", mem_timeout, 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        // load-use, then the bubble follows into EX while the load sits in MEM
        setin(2, 5, 5, 1, 0, 0, 0, 0, 1); cyc();
        setin(0, 0, 0, 0, 0, 0, 2, 0, 1); cyc();
        // unread source and x0 destination never stall
        setin(2, 5, 5, 0, 0, 0, 0, 0, 1); cyc();
        setin(2, 0, 0, 1, 0, 1, 0, 0, 1); cyc();
        // taken branch
        setin(0, 0, 0, 0, 0, 0, 0, 1, 1); cyc();
        setin(0, 0, 0, 0, 0, 0, 0, 0, 1); cyc(); cyc();
        // memory wait of three cycles
        setin(0, 0, 0, 0, 0, 0, 2, 0, 0); repeat (3) cyc();
        setin(0, 0, 0, 0, 0, 0, 2, 0, 1); cyc();
        setin(0, 0, 0, 0, 0, 0, 0, 0, 1); cyc();
        // memory never answers: timeout then release
        setin(0, 0, 0, 0, 0, 0, 3, 0, 0); repeat (TO + 1) cyc();
        setin(0, 0, 0, 0, 0, 0, 0, 0, 1); cyc(); cyc();
        // branch and load-use together
        setin(2, 5, 5, 1, 0, 0, 0, 1, 1); cyc();
        setin(0, 0, 0, 0, 0, 0, 0, 0, 1); cyc(); cyc();
        // branch then a wait while flushing, branch held through the wait
        setin(0, 0, 0, 0, 0, 0, 0, 1, 1); cyc();
        setin(0, 0, 0, 0, 0, 0, 10, 1, 0); repeat (2) cyc();
        setin(0, 0, 0, 0, 0, 0, 10, 1, 1); cyc();
        setin(0, 0, 0, 0, 0, 0, 0, 0, 1); repeat (3) cyc();

        repeat (3000) begin
            rand_in();
            cyc();
        end

        // asynchronous reset in the middle of a memory wait
        setin(0, 0, 0, 0, 0, 0, 2, 0, 0); repeat (2) cyc();
        rst_n = 1'b0;
        #1;
        check("rst_mid_ctrl", ctrl_vec(), 7'b0010100);
        check("rst_mid_stall", stall_cycles, 0);
        check("rst_mid_timeout", mem_timeout, 0);
        model_reset();
        @(posedge clk);
        #1;
        check("rst_hold_ctrl", ctrl_vec(), 7'b0010100);
        rst_n = 1'b1;
        setin(0, 0, 0, 0, 0, 0, 0, 0, 1); cyc();
        repeat (300) begin
            rand_in();
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
